// File: rtl/stack_unit_pkg.sv
// Shared definitions for the operand stack: stack-control encodings
// (identical to the constants the decoder drives) and the stack word type.
package stack_unit_pkg;

    localparam int STACK_WIDTH = 8;

    typedef logic [STACK_WIDTH-1:0] stack_word_t;

    // Stack-control code; 2'b11 is reserved and behaves like ADV_0.
    typedef enum logic [1:0] {
        ADV_0  = 2'b00,
        ADV_1  = 2'b01,
        DES_1  = 2'b10,
        SC_RSV = 2'b11
    } sc_e;

endpackage : stack_unit_pkg

// File: rtl/stack_unit_guard.sv
// Combinational legality check for one stack operation. Decides whether the
// array is written (and where), the count after the edge, and which sticky
// error (if any) the operation raises. Illegal operations change nothing.
module stack_unit_guard
    import stack_unit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic [1:0]    sc,
    input  logic          we,
    input  logic [PW-1:0] count,
    input  logic          full,
    input  logic          empty,
    output logic          do_write,
    output logic [PW-2:0] wr_idx,
    output logic [PW-1:0] next_count,
    output logic          set_ovf,
    output logic          set_unf
);

    localparam int AW = PW - 1;

    // Index arithmetic is done modulo DEPTH; at count==DEPTH the low bits are
    // zero, so count-1 still lands on DEPTH-1.
    logic [AW-1:0] idx_c0;
    logic [AW-1:0] idx_c1;
    logic [AW-1:0] idx_c2;

    assign idx_c0 = count[AW-1:0];
    assign idx_c1 = count[AW-1:0] - AW'(1);
    assign idx_c2 = count[AW-1:0] - AW'(2);

    // Decode the operation and apply the occupancy guards.
    always_comb begin
        do_write   = 1'b0;
        wr_idx     = '0;
        next_count = count;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        case (sc_e'(sc))
            ADV_1: begin
                if (full) begin
                    set_ovf = 1'b1;
                end else begin
                    do_write   = 1'b1;
                    wr_idx     = idx_c0;
                    next_count = count + PW'(1);
                end
            end
            DES_1: begin
                if (we) begin
                    if (count >= PW'(2)) begin
                        do_write   = 1'b1;
                        wr_idx     = idx_c2;
                        next_count = count - PW'(1);
                    end else begin
                        set_unf = 1'b1;
                    end
                end else if (!empty) begin
                    next_count = count - PW'(1);
                end else begin
                    set_unf = 1'b1;
                end
            end
            default: begin
                // ADV_0 and the reserved code: replace top, or do nothing.
                if (we) begin
                    if (!empty) begin
                        do_write = 1'b1;
                        wr_idx   = idx_c1;
                    end else begin
                        set_unf = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule : stack_unit_guard

// File: rtl/stack_unit.sv
// Operand stack: register array plus count, exposing top/second-of-stack as
// combinational reads of registered state, with sticky overflow/underflow.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       sc,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr_err,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] snd,
    output logic [PW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             do_write;
    logic [AW-1:0]    wr_idx;
    logic [PW-1:0]    next_count;
    logic             set_ovf;
    logic             set_unf;

    assign empty = (count_q == '0);
    assign full  = (count_q == PW'(DEPTH));

    stack_unit_guard #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_guard (
        .sc         (sc),
        .we         (we),
        .count      (count_q),
        .full       (full),
        .empty      (empty),
        .do_write   (do_write),
        .wr_idx     (wr_idx),
        .next_count (next_count),
        .set_ovf    (set_ovf),
        .set_unf    (set_unf)
    );

    // Next state: apply the guarded operation when enabled; clr_err acts even
    // while stalled, but a same-edge error wins over the clear.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (en) begin
            if (do_write) begin
                // we=0 on a push means "push zero"; every other write uses wdata.
                mem_d[wr_idx] = we ? wdata : '0;
            end
            count_d = next_count;
        end
        ovf_d = (clr_err ? 1'b0 : ovf_q) | (en & set_ovf);
        unf_d = (clr_err ? 1'b0 : unf_q) | (en & set_unf);
    end

    // State registers with asynchronous reset of the whole array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Read ports: popped entries stay in the array but are masked by count.
    logic [AW-1:0] top_idx;
    logic [AW-1:0] snd_idx;

    assign top_idx = count_q[AW-1:0] - AW'(1);
    assign snd_idx = count_q[AW-1:0] - AW'(2);

    assign top   = empty               ? '0 : mem_q[top_idx];
    assign snd   = (count_q < PW'(2))  ? '0 : mem_q[snd_idx];
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule : stack_unit

// File: tb/tb_stack_unit.sv
// Directed testbench for stack_unit with hand-computed expectations.
module tb_stack_unit;
    import stack_unit_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       sc;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic             clr_err;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] snd;
    logic [PW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    int n_checks = 0;
    int n_errors = 0;

    stack_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sc      (sc),
        .we      (we),
        .wdata   (wdata),
        .clr_err (clr_err),
        .top     (top),
        .snd     (snd),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operation, clock it, and settle just past the edge.
    task automatic step(input logic e, input logic [1:0] s, input logic w,
                        input logic [7:0] d, input logic c);
        en      = e;
        sc      = s;
        we      = w;
        wdata   = d;
        clr_err = c;
        @(posedge clk);
        #1;
        $display("op en=%0b sc=%0d we=%0b wdata=%02h clr=%0b -> count=%0d top=%02h snd=%02h ovf=%0b unf=%0b",
                 e, s, w, d, c, count, top, snd, ovf, unf);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sc = ADV_0; we = 1'b0; wdata = '0; clr_err = 1'b0;
        #12;
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_top",   32'(top),   0);
        check_eq("rst_snd",   32'(snd),   0);
        check_eq("rst_empty", 32'(empty), 1);
        check_eq("rst_full",  32'(full),  0);
        check_eq("rst_flags", {30'd0, ovf, unf}, 0);
        rst_n = 1'b1;
        #10;

        // Two pushes then a binary op result.
        step(1, ADV_1, 1, 8'h05, 0);
        step(1, ADV_1, 1, 8'h03, 0);
        check_eq("push2_count", 32'(count), 2);
        check_eq("push2_top",   32'(top),   8'h03);
        check_eq("push2_snd",   32'(snd),   8'h05);
        step(1, DES_1, 1, 8'h08, 0);
        check_eq("add_count", 32'(count), 1);
        check_eq("add_top",   32'(top),   8'h08);
        check_eq("add_snd",   32'(snd),   0);

        // Replace top, then pop to empty.
        step(1, ADV_0, 1, 8'h10, 0);
        check_eq("repl_top",   32'(top),   8'h10);
        check_eq("repl_count", 32'(count), 1);
        step(1, DES_1, 0, 8'h00, 0);
        check_eq("pop_empty", 32'(empty), 1);
        check_eq("pop_top",   32'(top),   0);

        // Fill to full, then overflow.
        for (int i = 1; i <= DEPTH; i++) step(1, ADV_1, 1, 8'(i), 0);
        check_eq("fill_full",  32'(full),  1);
        check_eq("fill_top",   32'(top),   16);
        check_eq("fill_snd",   32'(snd),   15);
        check_eq("fill_ovf",   32'(ovf),   0);
        step(1, ADV_1, 1, 8'hAA, 0);
        check_eq("ovf_top",   32'(top),   16);
        check_eq("ovf_count", 32'(count), 16);
        check_eq("ovf_set",   32'(ovf),   1);
        step(1, ADV_0, 0, 8'h00, 1);
        check_eq("ovf_clr",   32'(ovf),   0);

        // Drain, then underflow cases.
        for (int i = 0; i < DEPTH; i++) step(1, DES_1, 0, 8'h00, 0);
        check_eq("drain_empty", 32'(empty), 1);
        check_eq("drain_unf",   32'(unf),   0);
        step(1, ADV_1, 1, 8'h42, 0);
        step(1, DES_1, 1, 8'h99, 0);
        check_eq("unf_count", 32'(count), 1);
        check_eq("unf_top",   32'(top),   8'h42);
        check_eq("unf_set",   32'(unf),   1);
        step(1, DES_1, 0, 8'h00, 0);
        check_eq("pop42_empty", 32'(empty), 1);
        step(1, DES_1, 0, 8'h00, 0);
        check_eq("unf_empty_pop", 32'(unf),   1);
        check_eq("unf_empty_cnt", 32'(count), 0);
        step(1, ADV_0, 0, 8'h00, 1);
        check_eq("unf_clr", 32'(unf), 0);
        step(1, DES_1, 0, 8'h00, 1);
        check_eq("unf_set_wins", 32'(unf), 1);
        check_eq("ovf_clean",    32'(ovf), 0);

        // Reserved code acts as replace-top.
        step(1, ADV_1, 1, 8'h07, 0);
        step(1, SC_RSV, 1, 8'h09, 0);
        check_eq("rsv_top",   32'(top),   8'h09);
        check_eq("rsv_count", 32'(count), 1);

        // Stall: push has no effect.
        step(0, ADV_1, 1, 8'h07, 0);
        check_eq("stall_count", 32'(count), 1);
        check_eq("stall_top",   32'(top),   8'h09);
        check_eq("stall_unf",   32'(unf),   1);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", 32'(count), 0);
        check_eq("arst_top",   32'(top),   0);
        check_eq("arst_flags", {30'd0, ovf, unf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery plus push-zero.
        step(1, ADV_1, 1, 8'h33, 0);
        check_eq("rec_top", 32'(top), 8'h33);
        step(1, ADV_1, 0, 8'h5A, 0);
        check_eq("pz_count", 32'(count), 2);
        check_eq("pz_top",   32'(top),   0);
        check_eq("pz_snd",   32'(snd),   8'h33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_stack_unit
